// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer and the stage blocks it drives.
package stage_sequencer_pkg;

    // Default memory geometry shared with the stage blocks (2K x 16 data memory).
    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 16;

    // Sequencer FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERROR  = 3'd5
    } seq_state_t;

    // True in the states where the indexed stage owns its enable (and the memory).
    function automatic logic stage_owns_port(input seq_state_t st);
        return (st == ST_START) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/stage_sequencer_mem_port_mux.sv
// One-hot select mux from the per-stage write ports onto the shared memory write port.
// With no select bit set the memory port is held at zero, so no stage can write.
module mem_port_mux
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W
) (
    input  logic [NUM_STAGES-1:0]        sel,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
    input  logic [NUM_STAGES-1:0]        stage_wr_en,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_wr_en,
    output logic [DATA_W-1:0]            mem_wdata
);

    // AND-OR mux: each stage contributes only when its select bit is set.
    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (sel[i]) begin
                mem_addr  = mem_addr  | stage_addr[i*ADDR_W +: ADDR_W];
                mem_wr_en = mem_wr_en | stage_wr_en[i];
                mem_wdata = mem_wdata | stage_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Runs the stage blocks one after another with an en/start/done handshake,
// watches each stage with a timeout, and hands the shared memory write port
// to whichever stage is currently enabled.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned STAGE_W    = 2,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         go,
    output logic [NUM_STAGES-1:0]        stage_en,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
    input  logic [NUM_STAGES-1:0]        stage_wr_en,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_wr_en,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [STAGE_W-1:0]           active_stage,
    output logic                         busy,
    output logic                         all_done,
    output logic                         timeout_err
);

    localparam int unsigned        TIMER_W  = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);
    localparam logic [STAGE_W-1:0] LAST_IDX  = STAGE_W'(NUM_STAGES - 1);

    seq_state_t         state;
    seq_state_t         next_state;
    logic [STAGE_W-1:0] idx;
    logic [TIMER_W-1:0] timer;
    logic               cur_done;
    logic               timer_expired;

    // Only the active stage's done is ever looked at; strays from other stages vanish here.
    assign cur_done      = stage_done[idx];
    assign timer_expired = (timer == TIMER_MAX);

    // State register plus the stage index, WAIT timer and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;

            if (state == ST_IDLE && go) begin
                idx <= '0;
            end else if (state == ST_NEXT && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end

            if (state == ST_START) begin
                timer <= '0;
            end else if (state == ST_WAIT && !timer_expired) begin
                timer <= timer + 1'b1;
            end

            // An accepted go clears the flag; entering ERROR sets it so it is visible during ERROR.
            if (state == ST_IDLE && go) begin
                timeout_err <= 1'b0;
            end else if (next_state == ST_ERROR) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Next-state logic; in WAIT a done on the expiry cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   next_state = go ? ST_START : ST_IDLE;
            ST_START:  next_state = ST_WAIT;
            ST_WAIT: begin
                if (cur_done) begin
                    next_state = ST_NEXT;
                end else if (timer_expired) begin
                    next_state = ST_ERROR;
                end
            end
            ST_NEXT:   next_state = (idx == LAST_IDX) ? ST_FINISH : ST_START;
            ST_FINISH: next_state = ST_IDLE;
            ST_ERROR:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and index.
    always_comb begin
        stage_en    = '0;
        stage_start = '0;
        if (stage_owns_port(state)) begin
            stage_en[idx] = 1'b1;
        end
        if (state == ST_START) begin
            stage_start[idx] = 1'b1;
        end
        busy         = (state != ST_IDLE);
        all_done     = (state == ST_FINISH);
        active_stage = idx;
    end

    mem_port_mux #(
        .NUM_STAGES (NUM_STAGES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_mem_port_mux (
        .sel         (stage_en),
        .stage_addr  (stage_addr),
        .stage_wr_en (stage_wr_en),
        .stage_wdata (stage_wdata),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wdata   (mem_wdata)
    );

endmodule
